// File: rtl/shift_deser_pkg.sv
// Shared types and constants for the serial-in, parallel-out receiver.
package shift_deser_pkg;

    localparam int W_DEF = 8;

    localparam logic MSB_FIRST = 1'b0;
    localparam logic LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        PAR
    } state_t;

endpackage

// File: rtl/deser_bit_counter.sv
// Down-counter tracking the data bits left in the current word.
module deser_bit_counter #(
    parameter int NW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          step,
    input  logic [NW-1:0] n,
    output logic          last
);

    logic [NW-1:0] cnt;

    // On the first bit the count register is stale, so compare N directly.
    assign last = start ? (n == '0) : (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= last ? '0 : n - NW'(1);
        end else if (step) begin
            cnt <= last ? '0 : cnt - NW'(1);
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver with a one-entry valid/ready output.
// Define SHIFT_DESER_PARITY_EN for a trailing even-parity bit per word.
module shift_deserializer
    import shift_deser_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int NW = $clog2(W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sin,
    input  logic          sin_valid,
    input  logic          RnL,
    input  logic [NW-1:0] N,
    output logic [W-1:0]  out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          overrun,
    output logic          parity_err
);

`ifdef SHIFT_DESER_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    state_t        state;
    logic          cfg_rnl;
    logic [NW-1:0] cfg_n;
    logic [W-1:0]  sr;
    logic [W-1:0]  sr_next;
    logic [W-1:0]  src;
    logic [W-1:0]  mask;
    logic [W-1:0]  word;
    logic [NW-1:0] eff_n;
    logic [NW-1:0] sh;
    logic          eff_rnl;
    logic          first;
    logic          data_bit;
    logic          last;
    logic          complete;
    logic          load_out;

    assign first    = sin_valid && (state == IDLE);
    assign data_bit = sin_valid && (state != PAR);

    // The first bit of a word uses the live config; later bits the latched one.
    assign eff_rnl = (state == IDLE) ? RnL : cfg_rnl;
    assign eff_n   = (state == IDLE) ? N : cfg_n;

    assign sr_next = (eff_rnl == LSB_FIRST) ? {sin, sr[W-1:1]}
                                            : {sr[W-2:0], sin};

    // The parity bit never enters sr, so in PAR the word is already complete.
    assign src  = (state == PAR) ? sr : sr_next;
    assign sh   = NW'(W - 1) - eff_n;
    assign mask = {W{1'b1}} >> sh;
    assign word = (eff_rnl == LSB_FIRST) ? (src >> sh) : (src & mask);

    assign complete = PAR_EN ? (sin_valid && (state == PAR))
                             : (data_bit && last);
    assign load_out = complete && (!out_valid || out_ready);

    assign busy = (state != IDLE);

    deser_bit_counter #(
        .NW (NW)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .start (first),
        .step  (data_bit && !first),
        .n     (N),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cfg_rnl   <= 1'b0;
            cfg_n     <= '0;
            sr        <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (data_bit) begin
                sr <= sr_next;
            end
            if (first) begin
                cfg_rnl <= RnL;
                cfg_n   <= N;
            end

            case (state)
                IDLE, COLLECT: begin
                    if (data_bit) begin
                        if (!last) begin
                            state <= COLLECT;
                        end else if (PAR_EN) begin
                            state <= PAR;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                PAR: begin
                    if (sin_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (load_out) begin
                out       <= word;
                out_valid <= 1'b1;
            end else if (complete) begin
                overrun <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SHIFT_DESER_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else if (load_out) begin
            parity_err <= (^word) ^ sin;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer: vector table plus scoreboard.
module tb_shift_deserializer;

    import shift_deser_pkg::*;

`ifdef SHIFT_DESER_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       sin;
    logic       sin_valid;
    logic       RnL;
    logic [2:0] N;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       overrun;
    logic       parity_err;

    shift_deserializer #(
        .W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .RnL        (RnL),
        .N          (N),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // seq[i] is the i-th bit on the wire; exp is the word it must rebuild.
    typedef struct {
        logic       rnl;
        logic [2:0] n;
        logic [7:0] seq;
        int         gap;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] word;
        logic       perr;
    } sb_t;

    sb_t  q[$];
    sb_t  e_mon;
    vec_t vecs[10];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sin       = b;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
    endtask

    // Config is driven only with the first bit; later bits see it inverted.
    task automatic send_word(input logic rnl, input logic [2:0] n,
                             input logic [7:0] seq, input int gap,
                             input logic bad);
        logic p;
        p = bad;
        for (int i = 0; i <= int'(n); i++) begin
            if (i == 0) begin
                RnL = rnl;
                N   = n;
            end else begin
                RnL = ~rnl;
                N   = ~n;
            end
            p ^= seq[i];
            send_bit(seq[i]);
            if (i == 0) repeat (gap) tick();
        end
        if (PAR_EN) send_bit(p);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got %0h expected none", out);
            end else begin
                e_mon = q.pop_front();
                check("sb_word", out, e_mon.word);
                check("sb_parity_err", parity_err, e_mon.perr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s;

        vecs[0] = '{MSB_FIRST, 3'd7, 8'h33, 0, 8'hCC};
        vecs[1] = '{LSB_FIRST, 3'd7, 8'hAA, 0, 8'hAA};
        vecs[2] = '{LSB_FIRST, 3'd4, 8'h18, 2, 8'h18};
        vecs[3] = '{MSB_FIRST, 3'd2, 8'h05, 0, 8'h05};
        vecs[4] = '{MSB_FIRST, 3'd0, 8'h01, 0, 8'h01};
        vecs[5] = '{LSB_FIRST, 3'd0, 8'h01, 1, 8'h01};
        vecs[6] = '{LSB_FIRST, 3'd3, 8'h0D, 3, 8'h0D};
        vecs[7] = '{MSB_FIRST, 3'd5, 8'h21, 0, 8'h21};
        vecs[8] = '{MSB_FIRST, 3'd7, 8'h88, 0, 8'h11};
        vecs[9] = '{MSB_FIRST, 3'd7, 8'h44, 0, 8'h22};

        reset     = 1'b1;
        sin       = 1'b0;
        sin_valid = 1'b0;
        RnL       = 1'b0;
        N         = 3'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_out", out, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);

        foreach (vecs[i]) begin
            q.push_back('{vecs[i].exp, 1'b0});
            send_word(vecs[i].rnl, vecs[i].n, vecs[i].seq,
                      vecs[i].gap, 1'b0);
        end
        repeat (3) tick();

        // Completion latency and busy, with the output held.
        out_ready = 1'b0;
        q.push_back('{8'hCC, 1'b0});
        RnL = MSB_FIRST;
        N   = 3'd7;
        s   = 8'h33;
        for (int i = 0; i < 8; i++) send_bit(s[i]);
        check("valid_after_data", out_valid, !PAR_EN);
        check("busy_after_data", busy, PAR_EN);
        if (PAR_EN) send_bit(1'b0);
        check("valid_after_word", out_valid, 1'b1);
        check("busy_after_word", busy, 1'b0);
        check("held_word", out, 8'hCC);
        out_ready = 1'b1;
        repeat (2) tick();
        check("valid_after_pop", out_valid, 1'b0);

        // Second word arrives while the first is still held.
        out_ready = 1'b0;
        q.push_back('{8'h11, 1'b0});
        send_word(MSB_FIRST, 3'd7, 8'h88, 0, 1'b0);
        send_word(MSB_FIRST, 3'd7, 8'h44, 0, 1'b0);
        check("ovr_out", out, 8'h11);
        check("ovr_valid", out_valid, 1'b1);
        check("ovr_flag", overrun, 1'b1);
        out_ready = 1'b1;
        repeat (2) tick();
        check("ovr_sticky", overrun, 1'b1);

        // Reset mid-word, with a bit offered on the same edge.
        RnL = MSB_FIRST;
        N   = 3'd7;
        repeat (3) send_bit(1'b1);
        check("busy_mid_word", busy, 1'b1);
        sin       = 1'b1;
        sin_valid = 1'b1;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        sin_valid = 1'b0;
        check("mrst_out", out, 8'h00);
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_overrun", overrun, 1'b0);
        check("mrst_parity_err", parity_err, 1'b0);
        q.push_back('{8'h5A, 1'b0});
        send_word(MSB_FIRST, 3'd7, 8'h5A, 0, 1'b0);
        repeat (3) tick();
        check("post_rst_overrun", overrun, 1'b0);

        if (PAR_EN) begin
            q.push_back('{8'hCC, 1'b1});
            send_word(MSB_FIRST, 3'd7, 8'h33, 0, 1'b1);
            q.push_back('{8'hCC, 1'b0});
            send_word(MSB_FIRST, 3'd7, 8'h33, 0, 1'b0);
            repeat (3) tick();
        end

        check("sb_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
